// File: rtl/modradix4_pp_accum.sv
// modradix4_pp_accum: serial accumulator for radix-4 Booth partial products.
// Corrects, weights by 4^idx and sums NUM_PP digits, then hands off the product.
module modradix4_pp_accum #(
    parameter int WIDTH  = 8,
    parameter int NUM_PP = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      pp_valid,
    output logic                      pp_ready,
    input  logic [WIDTH:0]            pp_gen,
    input  logic                      pp_sign,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*WIDTH-1:0]        res_product,
    output logic [$clog2(NUM_PP)-1:0] pp_idx
);

    localparam int IDXW = $clog2(NUM_PP);
    localparam int ACCW = 2 * WIDTH + 2;

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] DONE  = 1'b1;

    localparam logic [IDXW-1:0] LAST = IDXW'(NUM_PP - 1);

    logic [0:0]      state;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] contrib;
    logic [ACCW-1:0] sum;
    logic [WIDTH+1:0] v;
    logic [IDXW:0]   shamt;
    logic            xfer;

    assign pp_ready  = (state == ACCUM);
    assign res_valid = (state == DONE);
    assign xfer      = pp_valid && pp_ready;

    // A set sign bit makes {sign,gen} equal gen - 2^(WIDTH+1); +1 finishes the negation.
    assign v       = {pp_sign, pp_gen} + {{(WIDTH + 1){1'b0}}, pp_sign};
    assign shamt   = {pp_idx, 1'b0};
    assign contrib = {{WIDTH{v[WIDTH+1]}}, v} << shamt;
    assign sum     = acc + contrib;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            acc         <= '0;
            pp_idx      <= '0;
            res_product <= '0;
        end else if (flush) begin
            state  <= ACCUM;
            acc    <= '0;
            pp_idx <= '0;
        end else if (state == ACCUM) begin
            if (xfer) begin
                if (pp_idx == LAST) begin
                    res_product <= sum[2*WIDTH-1:0];
                    state       <= DONE;
                    acc         <= '0;
                    pp_idx      <= '0;
                end else begin
                    acc    <= sum;
                    pp_idx <= pp_idx + 1'b1;
                end
            end
        end else if (res_ready) begin
            state <= ACCUM;
        end
    end

endmodule

// File: tb/tb_modradix4_pp_accum.sv
// tb_modradix4_pp_accum: directed and randomized checks of the Booth
// partial-product accumulator against an integer-arithmetic reference.
module tb_modradix4_pp_accum;

    localparam int WIDTH  = 8;
    localparam int NUM_PP = 5;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              pp_valid;
    logic              pp_ready;
    logic [WIDTH:0]    pp_gen;
    logic              pp_sign;
    logic              res_valid;
    logic              res_ready;
    logic [2*WIDTH-1:0] res_product;
    logic [2:0]        pp_idx;

    int tests;
    int fails;

    logic [WIDTH:0] gq[NUM_PP];
    logic           sq[NUM_PP];

    modradix4_pp_accum #(.WIDTH(WIDTH), .NUM_PP(NUM_PP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .pp_valid(pp_valid),
        .pp_ready(pp_ready),
        .pp_gen(pp_gen),
        .pp_sign(pp_sign),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_product(res_product),
        .pp_idx(pp_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Product = sum of signed digit values times 4^i, modulo 2^(2*WIDTH).
    function automatic logic [2*WIDTH-1:0] model_product();
        longint total;
        longint v;
        total = 0;
        for (int i = 0; i < NUM_PP; i++) begin
            v = longint'(gq[i]);
            if (sq[i])
                v = v - (longint'(1) << (WIDTH + 1)) + 1;
            total += v * (longint'(1) << (2 * i));
        end
        return total[2*WIDTH-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH:0] g, input logic s);
        pp_gen   = g;
        pp_sign  = s;
        pp_valid = 1'b1;
        tick();
        pp_valid = 1'b0;
        pp_gen   = $urandom();
        pp_sign  = $urandom();
    endtask

    task automatic send_all();
        for (int i = 0; i < NUM_PP; i++)
            send(gq[i], sq[i]);
    endtask

    task automatic set_digits(input logic [WIDTH:0] g0, input logic s0);
        for (int i = 0; i < NUM_PP; i++) begin
            gq[i] = '0;
            sq[i] = 1'b0;
        end
        gq[0] = g0;
        sq[0] = s0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (pp_ready !== 1'b1 || res_valid !== 1'b0 ||
            res_product !== 16'd0 || pp_idx !== 3'd0) begin
            $display("FAIL reset: ready=%b valid=%b prod=%h idx=%0d, need 1 0 0000 0",
                     pp_ready, res_valid, res_product, pp_idx);
            fails++;
        end
    endtask

    task automatic test_single_digit();
        set_digits(9'd13, 1'b0);
        for (int i = 0; i < NUM_PP - 1; i++)
            send(gq[i], sq[i]);
        tests++;
        if (res_valid !== 1'b0 || pp_idx !== 3'd4) begin
            $display("FAIL single_pre: valid=%b idx=%0d, need 0 4", res_valid, pp_idx);
            fails++;
        end
        send(gq[NUM_PP-1], sq[NUM_PP-1]);
        tests++;
        if (res_valid !== 1'b1 || res_product !== 16'd13 || pp_ready !== 1'b0) begin
            $display("FAIL single: valid=%b prod=%0d ready=%b, need 1 13 0",
                     res_valid, res_product, pp_ready);
            fails++;
        end
        handshake();
    endtask

    task automatic test_negative();
        set_digits(9'd498, 1'b1);
        gq[1] = 9'd26;
        send_all();
        tests++;
        if (res_valid !== 1'b1 || res_product !== 16'd91) begin
            $display("FAIL negative: valid=%b prod=%0d, need 1 91", res_valid, res_product);
            fails++;
        end
        handshake();
    endtask

    task automatic test_wrap();
        set_digits(9'h1FE, 1'b1);
        send_all();
        tests++;
        if (res_product !== 16'hFFFF) begin
            $display("FAIL wrap_neg: prod=%h, need ffff", res_product);
            fails++;
        end
        handshake();
        set_digits(9'd0, 1'b0);
        gq[4] = 9'd255;
        send_all();
        tests++;
        if (res_product !== 16'hFF00) begin
            $display("FAIL wrap_top: prod=%h, need ff00", res_product);
            fails++;
        end
        handshake();
    endtask

    task automatic test_backpressure();
        logic [2*WIDTH-1:0] exp;
        set_digits(9'd77, 1'b0);
        gq[2] = 9'd300;
        sq[3] = 1'b1;
        gq[3] = 9'd400;
        exp = model_product();
        send_all();
        pp_valid = 1'b1;
        pp_gen   = 9'd5;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (res_valid !== 1'b1 || res_product !== exp ||
                pp_ready !== 1'b0 || pp_idx !== 3'd0) begin
                $display("FAIL backpressure[%0d]: valid=%b prod=%h ready=%b idx=%0d, need 1 %h 0 0",
                         c, res_valid, res_product, pp_ready, pp_idx, exp);
                fails++;
            end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        pp_valid  = 1'b0;
        tests++;
        if (pp_ready !== 1'b1 || res_valid !== 1'b0 ||
            pp_idx !== 3'd0 || res_product !== exp) begin
            $display("FAIL release: ready=%b valid=%b idx=%0d prod=%h, need 1 0 0 %h",
                     pp_ready, res_valid, pp_idx, res_product, exp);
            fails++;
        end
    endtask

    task automatic test_flush();
        logic [2*WIDTH-1:0] prev;
        prev = res_product;
        send(9'd3, 1'b0);
        send(9'd7, 1'b1);
        flush    = 1'b1;
        pp_valid = 1'b1;
        pp_gen   = 9'd100;
        tick();
        flush    = 1'b0;
        pp_valid = 1'b0;
        tests++;
        if (pp_idx !== 3'd0 || res_valid !== 1'b0 || res_product !== prev) begin
            $display("FAIL flush: idx=%0d valid=%b prod=%h, need 0 0 %h",
                     pp_idx, res_valid, res_product, prev);
            fails++;
        end
        for (int i = 0; i < NUM_PP; i++) begin
            gq[i] = 9'd1;
            sq[i] = 1'b0;
        end
        send_all();
        tests++;
        if (res_valid !== 1'b1 || res_product !== 16'd341) begin
            $display("FAIL flush_after: valid=%b prod=%0d, need 1 341", res_valid, res_product);
            fails++;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests++;
        if (res_valid !== 1'b0 || pp_ready !== 1'b1 || res_product !== 16'd341) begin
            $display("FAIL flush_done: valid=%b ready=%b prod=%0d, need 0 1 341",
                     res_valid, pp_ready, res_product);
            fails++;
        end
    endtask

    task automatic test_async_reset();
        send(9'd9, 1'b0);
        send(9'd8, 1'b0);
        send(9'd7, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (pp_ready !== 1'b1 || res_valid !== 1'b0 ||
            res_product !== 16'd0 || pp_idx !== 3'd0) begin
            $display("FAIL async_reset: ready=%b valid=%b prod=%h idx=%0d, need 1 0 0000 0",
                     pp_ready, res_valid, res_product, pp_idx);
            fails++;
        end
        tick();
        rst_n = 1'b1;
        tick();
        set_digits(9'd200, 1'b1);
        gq[1] = 9'd45;
        gq[4] = 9'd17;
        send_all();
        tests++;
        if (res_valid !== 1'b1 || res_product !== model_product()) begin
            $display("FAIL post_reset: valid=%b prod=%h, need 1 %h",
                     res_valid, res_product, model_product());
            fails++;
        end
        handshake();
    endtask

    task automatic test_random();
        logic [2*WIDTH-1:0] exp;
        int wait_c;
        for (int p = 0; p < 25; p++) begin
            for (int i = 0; i < NUM_PP; i++) begin
                gq[i] = $urandom();
                sq[i] = $urandom();
            end
            exp = model_product();
            for (int i = 0; i < NUM_PP; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                tests++;
                if (pp_idx !== 3'(i) || pp_ready !== 1'b1) begin
                    $display("FAIL rand_idx[%0d.%0d]: idx=%0d ready=%b, need %0d 1",
                             p, i, pp_idx, pp_ready, i);
                    fails++;
                end
                send(gq[i], sq[i]);
            end
            wait_c = $urandom_range(0, 3);
            repeat (wait_c) tick();
            tests++;
            if (res_valid !== 1'b1 || res_product !== exp) begin
                $display("FAIL rand_prod[%0d]: valid=%b prod=%h, need 1 %h",
                         p, res_valid, res_product, exp);
                fails++;
            end
            handshake();
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        pp_valid  = 1'b0;
        pp_gen    = '0;
        pp_sign   = 1'b0;
        res_ready = 1'b0;
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_single_digit();
        test_negative();
        test_wrap();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
